// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with 2-entry skid buffer, flush and bubble ctrl zeroing
module pipe_skid_stage #(
    parameter int CTRL_W   = 10,
    parameter int DATA_W   = 67,
    parameter bit NEG_EDGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    output logic [1:0]        o_occupancy
);
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
    logic              act_clk;
    logic [1:0]        state, state_nxt;
    logic              accept, consume, load_main, load_skid, from_skid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    assign act_clk = NEG_EDGE ? ~clk : clk;
    always_ff @(posedge act_clk or posedge rst)
        if (rst) state <= EMPTY;
        else state <= state_nxt;
    // state equals occupancy, so the non-flush update is just +accept -consume
    always_comb begin
        accept    = i_valid & o_ready;
        consume   = o_valid & i_ready;
        state_nxt = i_flush ? EMPTY : state + 2'(accept) - 2'(consume);
        from_skid = state == TWO;
        load_main = (accept & (state == EMPTY | consume)) | (from_skid & consume);
        load_skid = accept & ~consume & state == ONE;
    end
    always_comb begin
        o_ready     = state != TWO;
        o_valid     = state != EMPTY;
        o_ctrl      = o_valid ? main_ctrl : '0;
        o_data      = main_data;
        o_occupancy = state;
    end
    always_ff @(posedge act_clk or posedge rst)
        if (rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (i_flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main) begin
                main_ctrl <= from_skid ? skid_ctrl : i_ctrl;
                main_data <= from_skid ? skid_data : i_data;
            end
            if (load_skid) begin
                skid_ctrl <= i_ctrl;
                skid_data <= i_data;
            end
        end
endmodule
